// File: rtl/dut_divider_pkg.sv
// Shared constants and types for the 36/18 iterative divider.
//   DIVIDEND_W : dividend/quotient width, also the number of iterations
//   DIVISOR_W  : divisor/remainder width
//   CNT_W      : width of the iteration counter (must hold DIVIDEND_W)
package dut_divider_pkg;

  localparam int DIVIDEND_W = 36;
  localparam int DIVISOR_W  = 18;
  localparam int CNT_W      = $clog2(DIVIDEND_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/dut_divider_step_comb.sv
// One radix-2 restoring division step (purely combinational).
//   rem_in       : partial remainder so far (always < divisor)
//   dividend_bit : next dividend bit, MSB first
//   divisor      : divisor (non-zero while iterating)
//   rem_out      : updated partial remainder
//   q_bit        : quotient bit produced by this step
module dut_divider_step_comb
  import dut_divider_pkg::*;
(
  input  logic [DIVISOR_W-1:0] rem_in,
  input  logic                 dividend_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] rem_out,
  output logic                 q_bit
);

  // The shifted remainder needs one extra bit: 2*rem+1 can reach 2*divisor-1.
  logic [DIVISOR_W:0] shifted;
  logic [DIVISOR_W:0] diff;
  logic [DIVISOR_W:0] result;
  logic               unused_result_msb;

  assign shifted = {rem_in, dividend_bit};
  assign diff    = shifted - {1'b0, divisor};
  assign q_bit   = (shifted >= {1'b0, divisor});
  assign result  = q_bit ? diff : shifted;

  // Either branch leaves a value below the divisor, so the top bit is always 0.
  assign rem_out           = result[DIVISOR_W-1:0];
  assign unused_result_msb = result[DIVISOR_W];

endmodule

// File: rtl/dut_divider_36x18_seq.sv
// Iterative unsigned divider, 36-bit dividend / 18-bit divisor, one quotient
// bit per clock, valid/ready handshakes on both sides.
//   clk, rst_n            : clock (rising edge), synchronous active-low reset
//   in_valid / in_ready   : operand handshake; operands sampled at the accept edge
//   dividend, divisor     : unsigned operands
//   out_valid / out_ready : result handshake; results held until accepted
//   quotient, remainder   : dividend / divisor, dividend % divisor
//   div_by_zero           : result came from a zero divisor
//   VDD, VSS              : supply pins, no logic function
module dut_divider_36x18_seq
  import dut_divider_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  input  logic                  VDD,
  input  logic                  VSS
);

  div_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  // Holds the dividend at accept; each step shifts one dividend bit out of the
  // top and one quotient bit in at the bottom, so it ends holding the quotient.
  logic [DIVIDEND_W-1:0] dq_q, dq_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
  logic                  dbz_q, dbz_d;

  logic [DIVISOR_W-1:0]  step_rem;
  logic                  step_q_bit;
  logic                  unused_supply;

  assign unused_supply = VDD ^ VSS;

  dut_divider_step_comb u_step (
    .rem_in       (rem_q),
    .dividend_bit (dq_q[DIVIDEND_W-1]),
    .divisor      (divisor_q),
    .rem_out      (step_rem),
    .q_bit        (step_q_bit)
  );

  // Handshake outputs decode registered state only.
  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = dq_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

  always_comb begin
    // NOTE: every signal gets a hold default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    cnt_d     = cnt_q;
    dq_d      = dq_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;
    dbz_d     = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          divisor_d = divisor;
          if (divisor == '0) begin
            dq_d    = '1;
            rem_d   = dividend[DIVISOR_W-1:0];
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            dq_d    = dividend;
            rem_d   = '0;
            dbz_d   = 1'b0;
            cnt_d   = CNT_W'(DIVIDEND_W);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        dq_d  = {dq_q[DIVIDEND_W-2:0], step_q_bit};
        rem_d = step_rem;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset too, because quotient/remainder read 0 out of reset.
      state_q   <= IDLE;
      cnt_q     <= '0;
      dq_q      <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      dbz_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dq_q      <= dq_d;
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
      dbz_q     <= dbz_d;
    end
  end

endmodule
